// File: rtl/chebyshev_sequencer.sv
// Sequencer in front of the Chebyshev core: accepts a sample, steps coefficients highest degree first,
// waits for the core pipeline to drain and hands the result downstream. Optional macro: CHEB_COEFF_SHADOW_EN.
module chebyshev_sequencer #(
    parameter int unsigned WL       = 16,
    parameter int unsigned CL       = 16,
    parameter int unsigned DEGREE   = 3,
    parameter int unsigned AW       = 2,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] in_data,
    input  logic          coeff_wr_en,
    input  logic [AW-1:0] coeff_wr_addr,
    input  logic [CL-1:0] coeff_wr_data,
    output logic          core_clear,
    output logic [WL-1:0] core_data,
    output logic [CL-1:0] core_coeff,
    input  logic [WL-1:0] core_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_data
);
    localparam int unsigned CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic [CW-1:0] step_cnt, step_cnt_nxt;
    logic          step_last, accept;
    logic          core_clear_nxt, out_valid_nxt;
    logic [WL-1:0] core_data_nxt, out_data_nxt;
    logic [CL-1:0] core_coeff_nxt;

    logic [CL-1:0] coef     [0:DEGREE];
    // Bank the next issued coefficient is read from, with any same-cycle write already merged in
    logic [CL-1:0] coef_src [0:DEGREE];

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && (state == IDLE);
    assign step_last = (step_cnt == CW'(PIPE_LAT - 1));

`ifdef CHEB_COEFF_SHADOW_EN
    logic [CL-1:0] shadow     [0:DEGREE];
    logic [CL-1:0] shadow_nxt [0:DEGREE];

    // Shadow bank takes writes at any time; the active bank snapshots it on sample accept
    always_comb begin
        for (int i = 0; i <= int'(DEGREE); i++) begin
            shadow_nxt[i] = shadow[i];
            if (coeff_wr_en && (coeff_wr_addr == AW'(i)))
                shadow_nxt[i] = coeff_wr_data;
            coef_src[i] = (state == IDLE) ? shadow_nxt[i] : coef[i];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= int'(DEGREE); i++) begin
                shadow[i] <= '0;
                coef[i]   <= '0;
            end
        end else begin
            for (int i = 0; i <= int'(DEGREE); i++) begin
                shadow[i] <= shadow_nxt[i];
                if (accept)
                    coef[i] <= shadow_nxt[i];
            end
        end
    end
`else
    logic [CL-1:0] coef_nxt [0:DEGREE];

    // Single bank, writable only while idle; out-of-range addresses match no entry
    always_comb begin
        for (int i = 0; i <= int'(DEGREE); i++) begin
            coef_nxt[i] = coef[i];
            if (coeff_wr_en && (state == IDLE) && (coeff_wr_addr == AW'(i)))
                coef_nxt[i] = coeff_wr_data;
            coef_src[i] = coef_nxt[i];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= int'(DEGREE); i++)
                coef[i] <= '0;
        end else begin
            for (int i = 0; i <= int'(DEGREE); i++)
                coef[i] <= coef_nxt[i];
        end
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and next-register values
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        step_cnt_nxt   = step_cnt;
        core_clear_nxt = 1'b0;
        core_data_nxt  = core_data;
        out_valid_nxt  = out_valid;
        out_data_nxt   = out_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    core_data_nxt  = in_data;
                    core_clear_nxt = 1'b1;
                    idx_nxt        = AW'(DEGREE);
                    step_cnt_nxt   = '0;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                step_cnt_nxt = step_cnt + CW'(1);
                if (step_last) begin
                    step_cnt_nxt = '0;
                    if (idx != '0)
                        idx_nxt = idx - AW'(1);
                    else
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                step_cnt_nxt = step_cnt + CW'(1);
                if (step_last) begin
                    step_cnt_nxt  = '0;
                    out_data_nxt  = core_result;
                    out_valid_nxt = 1'b1;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Coefficient presented while the next cycle is an ISSUE cycle, zero otherwise
    always_comb begin
        core_coeff_nxt = '0;
        if (state_nxt == ISSUE) begin
            for (int i = 0; i <= int'(DEGREE); i++)
                if (idx_nxt == AW'(i))
                    core_coeff_nxt = coef_src[i];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx        <= '0;
            step_cnt   <= '0;
            core_clear <= 1'b0;
            core_data  <= '0;
            core_coeff <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            idx        <= idx_nxt;
            step_cnt   <= step_cnt_nxt;
            core_clear <= core_clear_nxt;
            core_data  <= core_data_nxt;
            core_coeff <= core_coeff_nxt;
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
        end
    end
endmodule
